fiber_pe_arbiter: RTL and testbench

- Shares the single PE-side request port of one fiberBank between N_PE processing elements.
- Round-robin arbitrates requests and drives the bank's request handshake.
- Records which PE owns each response-bearing request in an in-order ID FIFO, and routes returning bank data to that PE.
- Sits between the PE crossbar and fiberBank; connects to the bank's request and response ports, which stay unmodified.

---
 rtl/fiber_pe_arbiter_if.sv | 65 ++++++
 rtl/fiber_pe_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_fiber_pe_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fiber_pe_arbiter_if.sv
// Bundle of every handshake and data signal between the PE-side arbiter,
// the PE crossbar and the fiberBank request/response ports.
// Signal names follow the arbiter's point of view (i_ = into the arbiter).
interface fiber_pe_arbiter_if #(
    parameter int N_PE            = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 8
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    // PE request side
    logic [N_PE-1:0]            i_pe_req_valid;
    logic [N_PE-1:0]            o_pe_req_ready;
    logic [4*N_PE-1:0]          i_pe_req_type;
    logic [ADDR_WIDTH*N_PE-1:0] i_pe_req_addr;
    logic [DATA_WIDTH*N_PE-1:0] i_pe_req_data;

    // Bank request side
    logic [3:0]                 o_request_type;
    logic [ADDR_WIDTH-1:0]      o_addr;
    logic [DATA_WIDTH-1:0]      o_data;
    logic                       o_type_valid;
    logic                       i_type_ready;

    // Bank response side
    logic [DATA_WIDTH-1:0]      i_pe_data_o;
    logic                       i_pe_data_o_valid;
    logic                       o_pe_data_o_ready;

    // PE response side
    logic [DATA_WIDTH-1:0]      o_pe_rsp_data;
    logic [N_PE-1:0]            o_pe_rsp_valid;
    logic [N_PE-1:0]            i_pe_rsp_ready;

    // Status
    logic [OUT_W-1:0]           o_outstanding;
    logic                       o_rsp_orphan;

    // The arbiter itself
    modport master (
        input  i_pe_req_valid, i_pe_req_type, i_pe_req_addr, i_pe_req_data,
        output o_pe_req_ready,
        output o_request_type, o_addr, o_data, o_type_valid,
        input  i_type_ready,
        input  i_pe_data_o, i_pe_data_o_valid,
        output o_pe_data_o_ready,
        output o_pe_rsp_data, o_pe_rsp_valid,
        input  i_pe_rsp_ready,
        output o_outstanding, o_rsp_orphan
    );

    // The surrounding PEs and bank
    modport slave (
        output i_pe_req_valid, i_pe_req_type, i_pe_req_addr, i_pe_req_data,
        input  o_pe_req_ready,
        input  o_request_type, o_addr, o_data, o_type_valid,
        output i_type_ready,
        output i_pe_data_o, i_pe_data_o_valid,
        input  o_pe_data_o_ready,
        input  o_pe_rsp_data, o_pe_rsp_valid,
        output i_pe_rsp_ready,
        input  o_outstanding, o_rsp_orphan
    );
endinterface

// File: rtl/fiber_pe_arbiter.sv
// Shares one fiberBank request port between N_PE processing elements.
// Round-robin grant, one request in flight toward the bank at a time, and an
// in-order ID FIFO that steers each returning data beat to the PE that asked.
// The parameters here must match the ones of the connected interface instance.
// MAX_OUTSTANDING must be a power of two >= 2 so the FIFO pointers wrap freely.
module fiber_pe_arbiter #(
    parameter int          N_PE            = 4,
    parameter int          DATA_WIDTH      = 16,
    parameter int          ADDR_WIDTH      = 64,
    parameter int          MAX_OUTSTANDING = 8,
    parameter logic [15:0] RESP_TYPE_MASK  = 16'h0002
) (
    input  logic                i_clk,
    input  logic                i_reset,
    fiber_pe_arbiter_if.master  bus
);
    localparam int PW    = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam int FW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [PW-1:0]         r_rrPtr;
    logic [PW-1:0]         r_winner;
    logic [3:0]            r_reqType;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;

    logic [PW-1:0]         r_idFifo [MAX_OUTSTANDING];
    logic [FW-1:0]         r_wrPtr;
    logic [FW-1:0]         r_rdPtr;
    logic [OUT_W-1:0]      r_count;
    logic                  r_orphan;

    logic [N_PE-1:0]       w_eligible;
    logic                  w_found;
    logic [PW-1:0]         w_winner;
    logic [N_PE-1:0]       w_grant;
    logic                  w_typeValid;
    logic                  w_issueDone;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_nonEmpty;
    logic [PW-1:0]         w_head;
    logic [N_PE-1:0]       w_rspValid;
    logic                  w_dataReady;

    // PE index reached by stepping 'offs' places up from 'base', wrapping at N_PE
    function automatic logic [PW-1:0] rotIdx(input logic [PW-1:0] base, input int offs);
        logic [PW:0] s;
        s = {1'b0, base} + (PW+1)'(offs);
        if (s >= (PW+1)'(N_PE)) begin
            s = s - (PW+1)'(N_PE);
        end
        return s[PW-1:0];
    endfunction

    assign w_full     = (r_count == OUT_W'(MAX_OUTSTANDING));
    assign w_nonEmpty = (r_count != '0);
    assign w_head     = r_idFifo[r_rdPtr];

    // A PE may compete unless it wants a response slot and the ID FIFO has none left
    always_comb begin
        w_eligible = '0;
        for (int p = 0; p < N_PE; p++) begin
            w_eligible[p] = bus.i_pe_req_valid[p] &&
                            (!RESP_TYPE_MASK[bus.i_pe_req_type[4*p +: 4]] || !w_full);
        end
    end

    // First eligible PE at or above the round-robin pointer, wrapping around
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < N_PE; i++) begin
            if (!w_found && w_eligible[rotIdx(r_rrPtr, i)]) begin
                w_found  = 1'b1;
                w_winner = rotIdx(r_rrPtr, i);
            end
        end
    end

    // Next-state and handshake outputs: grant only in IDLE, present to the bank only in ISSUE
    always_comb begin
        w_nextState = r_state;
        w_grant     = '0;
        w_typeValid = 1'b0;
        w_issueDone = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant[w_winner] = 1'b1;
                    w_nextState       = ISSUE;
                end
            end
            ISSUE: begin
                w_typeValid = 1'b1;
                if (bus.i_type_ready) begin
                    w_issueDone = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_push = w_issueDone && RESP_TYPE_MASK[r_reqType];

    // State register, latched request fields and round-robin pointer
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_rrPtr   <= '0;
            r_winner  <= '0;
            r_reqType <= '0;
            r_addr    <= '0;
            r_data    <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && w_found) begin
                r_winner  <= w_winner;
                r_reqType <= bus.i_pe_req_type[4*w_winner +: 4];
                r_addr    <= bus.i_pe_req_addr[ADDR_WIDTH*w_winner +: ADDR_WIDTH];
                r_data    <= bus.i_pe_req_data[DATA_WIDTH*w_winner +: DATA_WIDTH];
            end
            if (w_issueDone) begin
                r_rrPtr <= rotIdx(r_winner, 1);
            end
        end
    end

    // Response steering: the FIFO head owns the beat; with nothing pending the beat is swallowed
    always_comb begin
        w_rspValid  = '0;
        w_dataReady = 1'b1;
        if (w_nonEmpty) begin
            w_dataReady = bus.i_pe_rsp_ready[w_head];
            if (bus.i_pe_data_o_valid) begin
                w_rspValid[w_head] = 1'b1;
            end
        end
    end

    assign w_pop = bus.i_pe_data_o_valid && w_dataReady && w_nonEmpty;

    // ID FIFO pointers, occupancy and sticky orphan flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_count  <= '0;
            r_orphan <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count <= r_count + OUT_W'(w_push) - OUT_W'(w_pop);
            if (bus.i_pe_data_o_valid && !w_nonEmpty) begin
                r_orphan <= 1'b1;
            end
        end
    end

    // ID storage; contents are meaningless until pushed, so no reset is needed
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_idFifo[r_wrPtr] <= r_winner;
        end
    end

    assign bus.o_pe_req_ready    = w_grant;
    assign bus.o_type_valid      = w_typeValid;
    assign bus.o_request_type    = r_reqType;
    assign bus.o_addr            = r_addr;
    assign bus.o_data            = r_data;
    assign bus.o_pe_rsp_data     = bus.i_pe_data_o;
    assign bus.o_pe_rsp_valid    = w_rspValid;
    assign bus.o_pe_data_o_ready = w_dataReady;
    assign bus.o_outstanding     = r_count;
    assign bus.o_rsp_orphan      = r_orphan;

endmodule

// File: tb/tb_fiber_pe_arbiter.sv
// Self-checking bench for fiber_pe_arbiter: a table of hand-derived cycles,
// hand-written multi-cycle scenarios and a randomized run, all shadowed by a
// queue-based reference model of the arbitration and response routing rules.
module tb_fiber_pe_arbiter;
    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int AW   = 64;
    localparam int MAXO = 8;

    logic i_clk;
    logic i_reset;

    fiber_pe_arbiter_if #(.N_PE(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) bus ();

    fiber_pe_arbiter #(
        .N_PE(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO),
        .RESP_TYPE_MASK(16'h0002)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    // 100 MHz-style free-running clock
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        logic [N-1:0]    reqValid;
        logic [4*N-1:0]  reqType;
        logic [AW*N-1:0] reqAddr;
        logic [DW*N-1:0] reqData;
        logic            typeReady;
        logic            rspValid;
        logic [DW-1:0]   rspData;
        logic [N-1:0]    rspReady;
    } stim_t;

    typedef struct {
        bit            doRst;
        logic [N-1:0]  reqValid;
        logic [3:0]    reqType;
        logic [AW-1:0] addrBase;
        logic          typeReady;
        logic          rspValid;
        logic [DW-1:0] rspData;
        logic [N-1:0]  expReqReady;
        logic          expTypeValid;
        logic [AW-1:0] expAddr;
        logic [N-1:0]  expRspValid;
        logic          expDataReady;
        int            expOut;
    } vec_t;

    int assertCount = 0;
    int failCount   = 0;

    logic [15:0] respMask = 16'h0002;

    // Reference model state: pending request, last latched bank fields, owner queue
    stim_t         curStim;
    int            mQ[$];
    bit            mPend;
    int            mPendPe;
    logic [3:0]    mType;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mData;
    int            mRr;
    bit            mOrphan;
    int            mWinner;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic stim_t mkStim(input logic [N-1:0] valid, input logic [4*N-1:0] types,
                                     input logic [AW-1:0] base, input logic tr, input logic rv,
                                     input logic [DW-1:0] rdata, input logic [N-1:0] rrdy);
        stim_t s;
        s.reqValid  = valid;
        s.reqType   = types;
        for (int p = 0; p < N; p++) begin
            s.reqAddr[AW*p +: AW] = base + AW'(p);
            s.reqData[DW*p +: DW] = 16'hD000 + DW'(p);
        end
        s.typeReady = tr;
        s.rspValid  = rv;
        s.rspData   = rdata;
        s.rspReady  = rrdy;
        return s;
    endfunction

    function automatic stim_t idleStim();
        return mkStim('0, '0, '0, 1'b0, 1'b0, '0, '1);
    endfunction

    function automatic vec_t mkVec(input bit rst, input logic [N-1:0] valid, input logic [3:0] typ,
                                   input logic [AW-1:0] base, input logic tr, input logic rv,
                                   input logic [DW-1:0] rdata, input logic [N-1:0] eRdy,
                                   input logic eTv, input logic [AW-1:0] eAddr,
                                   input logic [N-1:0] eRsp, input logic eDr, input int eOut);
        vec_t v;
        v.doRst = rst; v.reqValid = valid; v.reqType = typ; v.addrBase = base;
        v.typeReady = tr; v.rspValid = rv; v.rspData = rdata;
        v.expReqReady = eRdy; v.expTypeValid = eTv; v.expAddr = eAddr;
        v.expRspValid = eRsp; v.expDataReady = eDr; v.expOut = eOut;
        return v;
    endfunction

    task automatic modelReset();
        mQ.delete();
        mPend   = 0;
        mPendPe = 0;
        mType   = '0;
        mAddr   = '0;
        mData   = '0;
        mRr     = 0;
        mOrphan = 0;
        mWinner = -1;
    endtask

    // Drive one cycle's inputs, let them settle, and compare every output to the model
    task automatic applyStimulus(input stim_t s);
        logic [N-1:0] eReady;
        logic [N-1:0] eRsp;
        logic         eDr;
        int           p;
        curStim                 = s;
        bus.i_pe_req_valid      = s.reqValid;
        bus.i_pe_req_type       = s.reqType;
        bus.i_pe_req_addr       = s.reqAddr;
        bus.i_pe_req_data       = s.reqData;
        bus.i_type_ready        = s.typeReady;
        bus.i_pe_data_o_valid   = s.rspValid;
        bus.i_pe_data_o         = s.rspData;
        bus.i_pe_rsp_ready      = s.rspReady;
        #2;
        mWinner = -1;
        if (!mPend) begin
            for (int k = 0; k < N; k++) begin
                p = (mRr + k) % N;
                if (s.reqValid[p] && (!respMask[s.reqType[4*p +: 4]] || mQ.size() < MAXO)) begin
                    mWinner = p;
                    break;
                end
            end
        end
        eReady = '0;
        if (mWinner >= 0) eReady[mWinner] = 1'b1;
        eRsp = '0;
        eDr  = 1'b1;
        if (mQ.size() > 0) begin
            eDr = s.rspReady[mQ[0]];
            if (s.rspValid) eRsp[mQ[0]] = 1'b1;
        end
        checkOutput("ref.reqReady",  64'(bus.o_pe_req_ready),    64'(eReady));
        checkOutput("ref.typeValid", 64'(bus.o_type_valid),      64'(mPend));
        checkOutput("ref.reqType",   64'(bus.o_request_type),    64'(mType));
        checkOutput("ref.addr",      64'(bus.o_addr),            64'(mAddr));
        checkOutput("ref.data",      64'(bus.o_data),            64'(mData));
        checkOutput("ref.rspValid",  64'(bus.o_pe_rsp_valid),    64'(eRsp));
        checkOutput("ref.rspData",   64'(bus.o_pe_rsp_data),     64'(s.rspData));
        checkOutput("ref.dataReady", 64'(bus.o_pe_data_o_ready), 64'(eDr));
        checkOutput("ref.outstand",  64'(bus.o_outstanding),     64'(mQ.size()));
        checkOutput("ref.orphan",    64'(bus.o_rsp_orphan),      64'(mOrphan));
    endtask

    // Advance the model across the clock edge, then move to just after that edge
    task automatic tick();
        stim_t s;
        s = curStim;
        if (s.rspValid) begin
            if (mQ.size() > 0) begin
                if (s.rspReady[mQ[0]]) void'(mQ.pop_front());
            end else begin
                mOrphan = 1;
            end
        end
        if (mPend) begin
            if (s.typeReady) begin
                if (respMask[mType]) mQ.push_back(mPendPe);
                mRr   = (mPendPe + 1) % N;
                mPend = 0;
            end
        end else if (mWinner >= 0) begin
            mPend   = 1;
            mPendPe = mWinner;
            mType   = s.reqType[4*mWinner +: 4];
            mAddr   = s.reqAddr[AW*mWinner +: AW];
            mData   = s.reqData[DW*mWinner +: DW];
        end
        @(posedge i_clk);
        #1;
    endtask

    // Hold reset for n edges, then confirm the cleared state with idle inputs
    task automatic doReset(input int n);
        i_reset = 1'b1;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
        i_reset = 1'b0;
        modelReset();
        applyStimulus(idleStim());
        checkOutput("rst.typeValid", 64'(bus.o_type_valid),   64'd0);
        checkOutput("rst.outstand",  64'(bus.o_outstanding),  64'd0);
        checkOutput("rst.orphan",    64'(bus.o_rsp_orphan),   64'd0);
        checkOutput("rst.addr",      64'(bus.o_addr),         64'd0);
        checkOutput("rst.data",      64'(bus.o_data),         64'd0);
        checkOutput("rst.reqType",   64'(bus.o_request_type), 64'd0);
        tick();
    endtask

    // Safety net so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t  vecs[14];
        stim_t s;
        int    pe3Grants;
        bit    found;

        i_reset = 1'b1;
        modelReset();
        curStim = idleStim();
        bus.i_pe_req_valid = '0; bus.i_pe_req_type = '0; bus.i_pe_req_addr = '0;
        bus.i_pe_req_data = '0; bus.i_type_ready = 1'b0; bus.i_pe_data_o_valid = 1'b0;
        bus.i_pe_data_o = '0; bus.i_pe_rsp_ready = '1;

        // Basic read from PE2 (addr base 0xFE so PE2 presents 0x100), then round-robin with type 2
        vecs[0]  = mkVec(1'b0, 4'b0100, 4'd1, 64'hFE,  1'b0, 1'b0, 16'h0,    4'b0100, 1'b0, 64'h0,   4'b0000, 1'b1, 0);
        vecs[1]  = mkVec(1'b0, 4'b0000, 4'd1, 64'hFE,  1'b1, 1'b0, 16'h0,    4'b0000, 1'b1, 64'h100, 4'b0000, 1'b1, 0);
        vecs[2]  = mkVec(1'b0, 4'b0000, 4'd1, 64'hFE,  1'b0, 1'b1, 16'hBEEF, 4'b0000, 1'b0, 64'h100, 4'b0100, 1'b1, 1);
        vecs[3]  = mkVec(1'b0, 4'b0000, 4'd1, 64'hFE,  1'b0, 1'b0, 16'h0,    4'b0000, 1'b0, 64'h100, 4'b0000, 1'b1, 0);
        vecs[4]  = mkVec(1'b1, 4'b1111, 4'd2, 64'h200, 1'b1, 1'b0, 16'h0,    4'b0001, 1'b0, 64'h0,   4'b0000, 1'b1, 0);
        vecs[5]  = mkVec(1'b0, 4'b1111, 4'd2, 64'h200, 1'b1, 1'b0, 16'h0,    4'b0000, 1'b1, 64'h200, 4'b0000, 1'b1, 0);
        vecs[6]  = mkVec(1'b0, 4'b1111, 4'd2, 64'h200, 1'b1, 1'b0, 16'h0,    4'b0010, 1'b0, 64'h200, 4'b0000, 1'b1, 0);
        vecs[7]  = mkVec(1'b0, 4'b1111, 4'd2, 64'h200, 1'b1, 1'b0, 16'h0,    4'b0000, 1'b1, 64'h201, 4'b0000, 1'b1, 0);
        vecs[8]  = mkVec(1'b0, 4'b1111, 4'd2, 64'h200, 1'b1, 1'b0, 16'h0,    4'b0100, 1'b0, 64'h201, 4'b0000, 1'b1, 0);
        vecs[9]  = mkVec(1'b0, 4'b1111, 4'd2, 64'h200, 1'b1, 1'b0, 16'h0,    4'b0000, 1'b1, 64'h202, 4'b0000, 1'b1, 0);
        vecs[10] = mkVec(1'b0, 4'b1111, 4'd2, 64'h200, 1'b1, 1'b0, 16'h0,    4'b1000, 1'b0, 64'h202, 4'b0000, 1'b1, 0);
        vecs[11] = mkVec(1'b0, 4'b1111, 4'd2, 64'h200, 1'b1, 1'b0, 16'h0,    4'b0000, 1'b1, 64'h203, 4'b0000, 1'b1, 0);
        vecs[12] = mkVec(1'b0, 4'b1111, 4'd2, 64'h200, 1'b1, 1'b0, 16'h0,    4'b0001, 1'b0, 64'h203, 4'b0000, 1'b1, 0);
        vecs[13] = mkVec(1'b0, 4'b1111, 4'd2, 64'h200, 1'b1, 1'b0, 16'h0,    4'b0000, 1'b1, 64'h200, 4'b0000, 1'b1, 0);

        doReset(2);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].doRst) doReset(2);
            applyStimulus(mkStim(vecs[i].reqValid, {N{vecs[i].reqType}}, vecs[i].addrBase,
                                 vecs[i].typeReady, vecs[i].rspValid, vecs[i].rspData, '1));
            checkOutput($sformatf("vec%0d.reqReady", i),  64'(bus.o_pe_req_ready),    64'(vecs[i].expReqReady));
            checkOutput($sformatf("vec%0d.typeValid", i), 64'(bus.o_type_valid),      64'(vecs[i].expTypeValid));
            checkOutput($sformatf("vec%0d.addr", i),      64'(bus.o_addr),            64'(vecs[i].expAddr));
            checkOutput($sformatf("vec%0d.rspValid", i),  64'(bus.o_pe_rsp_valid),    64'(vecs[i].expRspValid));
            checkOutput($sformatf("vec%0d.dataReady", i), 64'(bus.o_pe_data_o_ready), 64'(vecs[i].expDataReady));
            checkOutput($sformatf("vec%0d.outstand", i),  64'(bus.o_outstanding),     64'(vecs[i].expOut));
            tick();
        end

        // Backpressure: pointer now at PE1; bank stalls 5 cycles with every PE requesting
        s = mkStim(4'b1111, {N{4'd2}}, 64'h300, 1'b0, 1'b0, '0, '1);
        applyStimulus(s);
        checkOutput("bp.grant", 64'(bus.o_pe_req_ready), 64'b0010);
        tick();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(s);
            checkOutput("bp.typeValid", 64'(bus.o_type_valid),   64'd1);
            checkOutput("bp.addr",      64'(bus.o_addr),         64'h301);
            checkOutput("bp.data",      64'(bus.o_data),         64'hD001);
            checkOutput("bp.noReady",   64'(bus.o_pe_req_ready), 64'd0);
            tick();
        end
        s.typeReady = 1'b1;
        applyStimulus(s);
        tick();
        applyStimulus(s);
        checkOutput("bp.nextGrant", 64'(bus.o_pe_req_ready), 64'b0100);
        tick();

        // FIFO full: eight reads from PE0 without responses
        doReset(2);
        for (int r = 0; r < MAXO; r++) begin
            applyStimulus(mkStim(4'b0001, {N{4'd1}}, 64'h400, 1'b1, 1'b0, '0, '1));
            checkOutput("full.fillGrant", 64'(bus.o_pe_req_ready), 64'b0001);
            tick();
            applyStimulus(mkStim(4'b0000, {N{4'd1}}, 64'h400, 1'b1, 1'b0, '0, '1));
            tick();
        end
        s = mkStim(4'b1010, {4'd2, 4'd0, 4'd1, 4'd0}, 64'h500, 1'b1, 1'b0, '0, '1);
        pe3Grants = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(s);
            checkOutput("full.outstand", 64'(bus.o_outstanding),     64'd8);
            checkOutput("full.noPe1",    64'(bus.o_pe_req_ready[1]), 64'd0);
            if (bus.o_pe_req_ready[3]) pe3Grants++;
            tick();
        end
        checkOutput("full.pe3Grants", 64'(pe3Grants), 64'd4);
        s.rspValid = 1'b1;
        s.rspData  = 16'h1234;
        applyStimulus(s);
        checkOutput("full.rspToPe0", 64'(bus.o_pe_rsp_valid), 64'b0001);
        tick();
        s.rspValid = 1'b0;
        found = 0;
        for (int c = 0; c < 6 && !found; c++) begin
            applyStimulus(s);
            if (bus.o_pe_req_ready != '0) begin
                found = 1;
                checkOutput("full.pe1Next", 64'(bus.o_pe_req_ready), 64'b0010);
            end
            tick();
        end
        checkOutput("full.grantSeen", 64'(found), 64'd1);

        // Ordering and stall: PE3 read then PE0 read; PE3 holds off its beat
        doReset(2);
        applyStimulus(mkStim(4'b1000, {N{4'd1}}, 64'h600, 1'b1, 1'b0, '0, '1));
        tick();
        applyStimulus(mkStim(4'b0000, {N{4'd1}}, 64'h600, 1'b1, 1'b0, '0, '1));
        tick();
        applyStimulus(mkStim(4'b0001, {N{4'd1}}, 64'h600, 1'b1, 1'b0, '0, '1));
        tick();
        applyStimulus(mkStim(4'b0000, {N{4'd1}}, 64'h600, 1'b1, 1'b0, '0, '1));
        tick();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(mkStim('0, '0, '0, 1'b0, 1'b1, 16'hAAAA, 4'b0001));
            checkOutput("ord.stallValid", 64'(bus.o_pe_rsp_valid),    64'b1000);
            checkOutput("ord.stallReady", 64'(bus.o_pe_data_o_ready), 64'd0);
            checkOutput("ord.stallOut",   64'(bus.o_outstanding),     64'd2);
            tick();
        end
        applyStimulus(mkStim('0, '0, '0, 1'b0, 1'b1, 16'hAAAA, 4'b1000));
        checkOutput("ord.pe3Ready", 64'(bus.o_pe_data_o_ready), 64'd1);
        tick();
        applyStimulus(mkStim('0, '0, '0, 1'b0, 1'b1, 16'hBBBB, 4'b1111));
        checkOutput("ord.secondValid", 64'(bus.o_pe_rsp_valid), 64'b0001);
        checkOutput("ord.secondData",  64'(bus.o_pe_rsp_data),  64'hBBBB);
        checkOutput("ord.secondOut",   64'(bus.o_outstanding),  64'd1);
        tick();
        applyStimulus(idleStim());
        checkOutput("ord.drained", 64'(bus.o_outstanding), 64'd0);
        tick();

        // Orphan beat, then reset while a request sits in ISSUE with one ID pending
        doReset(2);
        applyStimulus(mkStim('0, '0, '0, 1'b0, 1'b1, 16'h5555, '0));
        checkOutput("orph.ready",    64'(bus.o_pe_data_o_ready), 64'd1);
        checkOutput("orph.rspValid", 64'(bus.o_pe_rsp_valid),    64'd0);
        tick();
        for (int c = 0; c < 2; c++) begin
            applyStimulus(idleStim());
            checkOutput("orph.sticky", 64'(bus.o_rsp_orphan), 64'd1);
            tick();
        end
        applyStimulus(mkStim(4'b0001, {N{4'd1}}, 64'h700, 1'b1, 1'b0, '0, '1));
        tick();
        applyStimulus(mkStim(4'b0000, {N{4'd1}}, 64'h700, 1'b1, 1'b0, '0, '1));
        tick();
        applyStimulus(mkStim(4'b0001, {N{4'd1}}, 64'h780, 1'b0, 1'b0, '0, '1));
        tick();
        applyStimulus(mkStim(4'b0001, {N{4'd1}}, 64'h780, 1'b0, 1'b0, '0, '1));
        checkOutput("orph.inIssue",  64'(bus.o_type_valid),  64'd1);
        checkOutput("orph.preOut",   64'(bus.o_outstanding), 64'd1);
        doReset(1);

        // Randomized traffic against the reference model
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(99) == 0) begin
                doReset(1);
            end else begin
                s.reqValid = N'($urandom);
                for (int p = 0; p < N; p++) begin
                    case ($urandom_range(3))
                        0, 1:    s.reqType[4*p +: 4] = 4'd1;
                        2:       s.reqType[4*p +: 4] = 4'd2;
                        default: s.reqType[4*p +: 4] = 4'($urandom);
                    endcase
                    s.reqAddr[AW*p +: AW] = {$urandom, $urandom};
                    s.reqData[DW*p +: DW] = DW'($urandom);
                end
                s.typeReady = ($urandom_range(9) < 7);
                s.rspValid  = ($urandom_range(9) < 3);
                s.rspData   = DW'($urandom);
                s.rspReady  = N'($urandom) | N'($urandom);
                applyStimulus(s);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
